// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and lock-state encoding for the sync generator
// and the sync decoder.
package vga_timing_pkg;

  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_BP_DEF        = 48;
  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_TOTAL_DEF     = 525;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_BP_DEF        = 33;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_t;

  // True when pos lies in [lo, lo+len).
  function automatic logic in_window(input logic [15:0] pos,
                                     input logic [15:0] lo,
                                     input logic [15:0] len);
    return (pos >= lo) && (pos < (lo + len));
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for one active-low sync line plus a leading (falling)
// edge detector evaluated only on pixel-strobe cycles.
module sync_edge_detect (
  input  logic board_clk,
  input  logic reset,
  input  logic pix_en,
  input  logic sync_n,
  output logic lead_edge
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d    = sync_n;
    sync_d    = meta_q;
    prev_d    = prev_q;
    lead_edge = 1'b0;
    if (pix_en) begin
      // Edge is judged against the level seen on the previous pixel strobe.
      prev_d    = sync_q;
      lead_edge = prev_q && !sync_q;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from incoming VGA sync lines, checks line and frame
// lengths, and tracks lock through a SEARCH -> ACQUIRE -> LOCKED state machine.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       in_display,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic [7:0] err_count
);

  localparam int HCW     = $clog2(2 * H_TOTAL);
  localparam int GW      = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_MAX  = HCW'(2 * H_TOTAL - 1);
  localparam logic [HCW-1:0] H_PRE  = HCW'(2 * H_TOTAL - 2);
  localparam logic [9:0]     V_LAST = 10'(V_TOTAL - 1);
  localparam logic [GW-1:0]  G_LAST = GW'(LOCK_FRAMES - 1);

  logic h_edge, v_edge;

  sync_edge_detect u_hsync_edge (
    .board_clk (board_clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .sync_n    (vga_h_sync),
    .lead_edge (h_edge)
  );

  sync_edge_detect u_vsync_edge (
    .board_clk (board_clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .sync_n    (vga_v_sync),
    .lead_edge (v_edge)
  );

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [9:0]     v_cnt_q, v_cnt_d;
  logic           vs_pend_q, vs_pend_d;
  logic           h_valid_q, h_valid_d;
  sync_state_t    state_q, state_d;
  logic [GW-1:0]  good_q, good_d;

  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic       in_display_q, in_display_d;
  logic       locked_q, locked_d;
  logic       frame_start_q, frame_start_d;
  logic       sync_err_q, sync_err_d;
  logic [7:0] err_count_q, err_count_d;

  logic line_err, frame_err, frame_evt, err_hit;
  logic h_vis, v_vis;

  // Position counters and raw timing-error detection.
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    vs_pend_d = vs_pend_q;
    line_err  = 1'b0;
    frame_err = 1'b0;
    frame_evt = 1'b0;
    if (pix_en) begin
      if (h_edge) begin
        line_err = h_valid_q && (h_cnt_q != H_LAST);
        h_cnt_d  = '0;
        // A vsync edge on this very strobe counts as already pending.
        if (vs_pend_q || v_edge) begin
          frame_evt = 1'b1;
          frame_err = (v_cnt_q != V_LAST);
          v_cnt_d   = '0;
          vs_pend_d = 1'b0;
        end else if (v_cnt_q != 10'h3FF) begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        if (v_edge) begin
          vs_pend_d = 1'b1;
        end
        if (h_cnt_q != H_MAX) begin
          h_cnt_d  = h_cnt_q + 1'b1;
          line_err = (h_cnt_q == H_PRE);
        end
      end
    end
  end

  // Lock state machine; errors only matter once a frame has been seen.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    h_valid_d = h_valid_q;
    err_hit   = (line_err || frame_err) && (state_q != ST_SEARCH);
    if (pix_en && h_edge) begin
      h_valid_d = 1'b1;
    end
    unique case (state_q)
      ST_SEARCH: begin
        if (frame_evt) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (err_hit) begin
          state_d = ST_SEARCH;
        end else if (frame_evt) begin
          if (good_q == G_LAST) begin
            state_d = ST_LOCKED;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (err_hit) begin
          state_d = ST_SEARCH;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
    // The next line measured after dropping to SEARCH starts from an unknown phase.
    if (err_hit) begin
      h_valid_d = 1'b0;
    end
  end

  // Outputs track the post-strobe counter values so they land one clock later.
  always_comb begin
    h_vis         = in_window(16'(h_cnt_d), 16'(H_START), 16'(H_ACTIVE));
    v_vis         = in_window(16'(v_cnt_d), 16'(V_START), 16'(V_ACTIVE));
    pix_x_d       = '0;
    pix_y_d       = '0;
    if (h_vis && v_vis) begin
      pix_x_d = 10'(h_cnt_d - HCW'(H_START));
      pix_y_d = v_cnt_d - 10'(V_START);
    end
    locked_d      = (state_d == ST_LOCKED);
    in_display_d  = h_vis && v_vis && locked_d;
    frame_start_d = frame_evt;
    sync_err_d    = err_hit;
    err_count_d   = err_count_q;
    if (err_hit && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vs_pend_q     <= 1'b0;
      h_valid_q     <= 1'b0;
      state_q       <= ST_SEARCH;
      good_q        <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      in_display_q  <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_pend_q     <= vs_pend_d;
      h_valid_q     <= h_valid_d;
      state_q       <= state_d;
      good_q        <= good_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      in_display_q  <= in_display_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign in_display  = in_display_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a scaled-down raster and a
// per-pixel behavioural model of the decoder.
module tb_vga_sync_decoder;

  localparam int HT = 24;
  localparam int HS = 3;
  localparam int HB = 4;
  localparam int HA = 14;
  localparam int VT = 14;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 8;
  localparam int LOCKF = 2;
  localparam int HA0 = HS + HB;
  localparam int VA0 = VS + VB;

  logic       board_clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       in_display;
  logic       locked;
  logic       frame_start;
  logic       sync_err;
  logic [7:0] err_count;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
    .LOCK_FRAMES(LOCKF)
  ) dut (
    .board_clk   (board_clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .vga_h_sync  (vga_h_sync),
    .vga_v_sync  (vga_v_sync),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .in_display  (in_display),
    .locked      (locked),
    .frame_start (frame_start),
    .sync_err    (sync_err),
    .err_count   (err_count)
  );

  always #5 board_clk = ~board_clk;

  // Reference model state: pixel position, lock state (0 search, 1 acquire, 2 locked).
  int m_h, m_v, m_state, m_good, m_errc;
  bit m_ph, m_pv, m_pend, m_hvalid, e_fs, e_err;

  int n_cmp = 0;
  int n_err = 0;
  int fs_obs, se_obs, lock_fs, vis_hits;
  bit k_fixed, chk_vis;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_state = 0; m_good = 0; m_errc = 0;
    m_ph = 1'b1; m_pv = 1'b1; m_pend = 1'b0; m_hvalid = 1'b0;
    e_fs = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_pixel(input logic h, input logic v);
    bit he, ve, lerr, ferr;
    he = m_ph && !h;
    ve = m_pv && !v;
    m_ph = h;
    m_pv = v;
    lerr = 1'b0;
    ferr = 1'b0;
    e_fs = 1'b0;
    if (he) begin
      if (m_hvalid && m_h != HT - 1) lerr = 1'b1;
      m_h = 0;
      m_hvalid = 1'b1;
      if (m_pend || ve) begin
        e_fs = 1'b1;
        if (m_v != VT - 1) ferr = 1'b1;
        m_v = 0;
        m_pend = 1'b0;
      end else if (m_v < 1023) begin
        m_v = m_v + 1;
      end
    end else begin
      if (ve) m_pend = 1'b1;
      if (m_h < 2 * HT - 1) begin
        m_h = m_h + 1;
        if (m_h == 2 * HT - 1) lerr = 1'b1;
      end
    end
    e_err = (lerr || ferr) && (m_state != 0);
    if (e_err) begin
      m_state = 0;
      m_hvalid = 1'b0;
      if (m_errc < 255) m_errc = m_errc + 1;
    end else if (e_fs) begin
      if (m_state == 0) begin
        m_state = 1;
        m_good = 0;
      end else if (m_state == 1) begin
        m_good = m_good + 1;
        if (m_good >= LOCKF) m_state = 2;
      end
    end
  endtask

  function automatic logic [31:0] exp_vec();
    bit ins;
    logic [9:0] x, y;
    ins = (m_h >= HA0) && (m_h < HA0 + HA) && (m_v >= VA0) && (m_v < VA0 + VA);
    x = ins ? 10'(m_h - HA0) : 10'd0;
    y = ins ? 10'(m_v - VA0) : 10'd0;
    return {x, y, ins && (m_state == 2), m_state == 2, e_fs, e_err, 8'(m_errc)};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {pix_x, pix_y, in_display, locked, frame_start, sync_err, err_count};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s at h=%0d v=%0d observed=%h expected=%h", tag, m_h, m_v, o, e);
    end
  endtask

  function automatic int pick_k();
    return k_fixed ? 4 : int'($urandom_range(5, 3));
  endfunction

  // One pixel: hold the sync levels for k clocks, strobing pix_en on the last.
  task automatic pixel(input logic h, input logic v, input int k);
    vga_h_sync = h;
    vga_v_sync = v;
    @(negedge board_clk);
    chk("pulse_one_cycle", {30'd0, frame_start, sync_err}, 32'd0);
    repeat (k - 2) @(negedge board_clk);
    pix_en = 1'b1;
    @(negedge board_clk);
    pix_en = 1'b0;
    model_pixel(h, v);
    if (frame_start === 1'b1) fs_obs++;
    if (sync_err === 1'b1) se_obs++;
    if (locked === 1'b1 && lock_fs < 0) lock_fs = fs_obs;
    chk("pixel", obs_vec(), exp_vec());
  endtask

  task automatic vis_hooks();
    if (chk_vis && m_state == 2 && m_v == VA0) begin
      if (m_h == HA0) begin
        vis_hits++;
        chk("first_visible", {12'd0, pix_x, pix_y}, 32'd0);
        chk("first_visible_disp", 32'(in_display), 32'd1);
      end else if (m_h == HA0 + HA - 1) begin
        vis_hits++;
        chk("last_visible_x", 32'(pix_x), 32'(HA - 1));
      end else if (m_h == HA0 + HA) begin
        vis_hits++;
        chk("past_visible_disp", 32'(in_display), 32'd0);
      end
    end
  endtask

  // Emits n_lines of a frame; short_line (if in range) is one pixel short.
  // vsync may fall early inside the last line, still landing on line 0's hsync.
  task automatic gen_frame(input int short_line, input int n_lines);
    bit early;
    int epos, len;
    logic h, v;
    early = 1'($urandom_range(1, 0));
    epos  = int'($urandom_range(HT - 1, 1));
    for (int ln = 0; ln < n_lines; ln++) begin
      len = (ln == short_line) ? HT - 1 : HT;
      for (int px = 0; px < len; px++) begin
        h = (px >= HS);
        v = !((ln < VS) || (ln == VT - 1 && early && px >= epos));
        pixel(h, v, pick_k());
        vis_hooks();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int se0;
    reset = 1'b1;
    pix_en = 1'b0;
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    k_fixed = 1'b1;
    chk_vis = 1'b0;
    fs_obs = 0; se_obs = 0; lock_fs = -1; vis_hits = 0;
    model_reset();
    repeat (3) @(negedge board_clk);
    chk("reset_outputs", obs_vec(), 32'd0);
    reset = 1'b0;

    $display("step 1: nominal frames, pix_en every 4th clock");
    for (int f = 0; f < 4; f++) gen_frame(-1, VT);
    chk("lock_at_third_frame_start", 32'(lock_fs), 32'd3);
    chk("nominal_err_count", 32'(err_count), 32'd0);
    chk("nominal_locked", 32'(locked), 32'd1);

    $display("step 2: visible window edges with jittered pixel strobe");
    k_fixed = 1'b0;
    chk_vis = 1'b1;
    gen_frame(-1, VT);
    chk_vis = 1'b0;
    chk("visible_hooks_hit", 32'(vis_hits), 32'd3);

    $display("step 3: one short line while locked, then relock");
    se0 = se_obs;
    gen_frame(5, VT);
    chk("short_err_pulses", 32'(se_obs - se0), 32'd1);
    chk("short_err_count", 32'(err_count), 32'd1);
    chk("short_unlocked", 32'(locked), 32'd0);
    for (int f = 0; f < 3; f++) gen_frame(-1, VT);
    chk("short_relocked", 32'(locked), 32'd1);

    $display("step 4: hsync missing for two line periods");
    se0 = se_obs;
    gen_frame(-1, 4);
    for (int p = 0; p < 2 * HT; p++) pixel(1'b1, 1'b1, pick_k());
    chk("missing_err_pulses", 32'(se_obs - se0), 32'd1);
    chk("missing_err_count", 32'(err_count), 32'd2);
    chk("missing_unlocked", 32'(locked), 32'd0);
    for (int f = 0; f < 3; f++) gen_frame(-1, VT);
    chk("missing_no_extra_errs", 32'(se_obs - se0), 32'd1);
    chk("missing_relocked", 32'(locked), 32'd1);

    $display("step 5: 300 forced timing errors");
    for (int i = 0; i < 300; i++) begin
      pixel(1'b1, 1'b1, 3);
      pixel(1'b0, 1'b0, 3);
      pixel(1'b1, 1'b1, 3);
      pixel(1'b1, 1'b1, 3);
      pixel(1'b0, 1'b1, 3);
    end
    chk("err_count_saturated", 32'(err_count), 32'd255);

    $display("step 6: reset asserted mid-frame, then reacquire");
    gen_frame(-1, VT);
    gen_frame(-1, 5);
    #2 reset = 1'b1;
    #1 chk("reset_mid_frame", obs_vec(), 32'd0);
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    repeat (2) @(negedge board_clk);
    reset = 1'b0;
    model_reset();
    fs_obs = 0;
    lock_fs = -1;
    for (int f = 0; f < 4; f++) gen_frame(-1, VT);
    chk("post_reset_lock_fs", 32'(lock_fs), 32'd3);
    chk("post_reset_locked", 32'(locked), 32'd1);
    chk("post_reset_err_count", 32'(err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, 800, pixels per line including blanking.
REQ-002 SHALL have parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-003 SHALL have parameter H_BP, 48, back porch; active x starts at H_SYNC+H_BP.
REQ-004 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-005 SHALL have parameters V_TOTAL 525, V_SYNC 2, V_BP 33, V_ACTIVE 480, in lines.
REQ-006 SHALL have parameter LOCK_FRAMES, 2, consecutive good frames required to lock.
REQ-007 SHALL have port board_clk, input, 1, system clock.
REQ-008 SHALL have port reset, input, 1; reset is asynchronous and active-high; the clock is board_clk.
REQ-009 SHALL have port pix_en, input, 1, pixel-rate strobe; all sync sampling and counting happen only on cycles with pix_en=1.
REQ-010 SHALL have ports vga_h_sync and vga_v_sync, input, 1 each, active-low sync lines.
REQ-011 SHALL have port pix_x, output, 10, recovered column; pix_y, output, 10, recovered row.
REQ-012 SHALL have port in_display, output, 1, high when the recovered position is in the active area.
REQ-013 SHALL have port locked, output, 1; frame_start, output, 1, one-cycle pulse; sync_err, output, 1, one-cycle pulse; err_count, output, 8, saturating error count.

Function
REQ-014 SHALL pass each sync line through a 2-flop synchronizer on board_clk; a leading edge is synchronized sample 0 on a pix_en cycle where the previous pix_en sample was 1.
REQ-015 SHALL keep h_cnt: 0 on a pix_en cycle with an hsync leading edge, else h_cnt+1 on pix_en, saturating at 2*H_TOTAL-1.
REQ-016 SHALL flag a line-length error when an hsync leading edge arrives with h_cnt != H_TOTAL-1 (excluding the first edge after SEARCH), or when h_cnt reaches 2*H_TOTAL-1 (missing hsync).
REQ-017 SHALL set a vsync-pending flag on a vsync leading edge; at the next hsync leading edge (including the same pix_en cycle) v_cnt <= 0, pending clears, frame_start pulses; otherwise v_cnt increments on each hsync leading edge, saturating at 1023.
REQ-018 SHALL flag a frame-length error when v_cnt is cleared with v_cnt != V_TOTAL-1 while in ACQUIRE or LOCKED.
REQ-019 SHALL drive pix_x = h_cnt-(H_SYNC+H_BP) and pix_y = v_cnt-(V_SYNC+V_BP) when both are inside the active window, else 0; in_display=1 only inside the window and only while locked.
REQ-020 SHALL implement states SEARCH, ACQUIRE, LOCKED: SEARCH->ACQUIRE on first frame_start; ACQUIRE counts good frames, ->LOCKED after LOCK_FRAMES error-free frames; any error in ACQUIRE or LOCKED ->SEARCH.
REQ-021 SHALL assert locked only in LOCKED.
REQ-022 SHALL pulse sync_err for one board_clk cycle per detected error and increment err_count, saturating at 255; errors in SEARCH are not counted.
REQ-023 SHALL register all outputs; outputs update one board_clk cycle after the pix_en cycle that changes h_cnt/v_cnt.

Reset
REQ-024 SHALL on reset clear synchronizers to 1 (idle), h_cnt, v_cnt, pix_x, pix_y, err_count to 0, deassert locked, in_display, frame_start, sync_err, and enter SEARCH.
REQ-025 SHALL, on reset asserted mid-frame, abandon the frame and re-acquire from SEARCH after release.

Structure
REQ-026 SHALL place the timing parameter defaults and the state encoding in shared package vga_timing_pkg, also used by the sync generator.
REQ-027 SHALL use one sub-module, sync_edge_detect (2-flop synchronizer plus pix_en-gated leading-edge detect), instantiated once per sync line.

Verification
REQ-028 Nominal 800x525 timing, pix_en every 4th board_clk -> locked rises at the 3rd frame_start after reset release, err_count=0.
REQ-029 Locked; first visible pixel (h_cnt=144, v_cnt=35) -> pix_x=0, pix_y=0, in_display=1; h_cnt=783 -> pix_x=639; h_cnt=784 -> in_display=0.
REQ-030 Locked; one line shortened to 799 pixels -> one sync_err pulse, err_count=1, locked=0 next cycle, relock after 2 further good frames.
REQ-031 Locked; hsync held high for 1600 pixels -> sync_err on saturation, state SEARCH, no further errors counted until a frame_start.
REQ-032 Vsync leading edge on same pix_en cycle as hsync leading edge -> v_cnt=0 that cycle, one frame_start pulse.
REQ-033 300 forced frame errors -> err_count saturates at 255; reset mid-frame -> all outputs 0, state SEARCH.
